// File: rtl/al_accel_pkg.sv
// Shared definitions for the input-buffer scan sequencer and its fetch unit.
package al_accel_pkg;

    localparam int unsigned ADDR_W    = 16;
    localparam int unsigned CFG_W     = 8;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned SHIFT_LEN = 4;
    localparam int unsigned SH_W      = $clog2(SHIFT_LEN);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_SHIFT,
        ST_STEP,
        ST_DOWN,
        ST_SWAP,
        ST_FIN
    } state_t;

    typedef logic [1:0] bank_t;

    localparam bank_t BANK_1 = 2'd1;
    localparam bank_t BANK_2 = 2'd2;
    localparam bank_t BANK_3 = 2'd3;

    // One-hot write strobe for a bank code (bank 1 -> bit 0).
    function automatic logic [2:0] bank_strb(input bank_t b);
        logic [2:0] s;
        s = '0;
        case (b)
            BANK_1:  s = 3'b001;
            BANK_2:  s = 3'b010;
            BANK_3:  s = 3'b100;
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/al_accel_ibuf_fetch.sv
// Single-outstanding memory read unit with a running row-base accumulator.
module al_accel_ibuf_fetch
    import al_accel_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              enb,
    input  logic              req,
    input  logic              row_load,
    input  logic [ADDR_W-1:0] row_load_val,
    input  logic [CFG_W-1:0]  col,
    input  logic [CFG_W-1:0]  cfg_w,
    output logic              mem_rreq,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              ack,
    output logic [DATA_W-1:0] ibuf_di,
    output logic              ibuf_ld_wrn
);

    logic [ADDR_W-1:0] row_q, row_d;

    // Request/address decode; the address only moves on an accepted word.
    always_comb begin
        mem_rreq    = req;
        mem_raddr   = row_q + ADDR_W'(col);
        ack         = req & mem_rvalid & enb;
        ibuf_ld_wrn = ack;
        ibuf_di     = ack ? mem_rdata : '0;
    end

    // Row base: reload at the top of a fetch group, advance one row per word.
    always_comb begin
        row_d = row_q;
        if (enb) begin
            if (row_load) begin
                row_d = row_load_val;
            end else if (ack) begin
                row_d = row_q + ADDR_W'(cfg_w);
            end
        end
    end

    // Row base register.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_q <= '0;
        end else begin
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/al_accel_ibuf_seq.sv
// Serpentine 3-row band scanner feeding the convolution input buffer.
module al_accel_ibuf_seq
    import al_accel_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              enb,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [CFG_W-1:0]  cfg_w,
    input  logic [CFG_W-1:0]  cfg_h,
    output logic              mem_rreq,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] ibuf_di,
    output logic              ibuf_ld_wrn,
    output logic [1:0]        ibuf_bank_sel,
    output logic              ibuf_di_revert,
    output logic [2:0]        ibuf_conv_wstrb,
    output logic              ibuf_conv_fi_load,
    output logic              ibuf_conv_se_load,
    output logic              win_valid,
    output logic              busy,
    output logic              done
);

    state_t            state_q, state_d;
    logic [CFG_W-1:0]  r_q, r_d;
    logic [CFG_W-1:0]  col_q, col_d;
    logic [1:0]        k_q, k_d;
    logic [SH_W-1:0]   sh_q, sh_d;
    logic              revert_q, revert_d;
    logic [ADDR_W-1:0] band_q, band_d;
    logic [CFG_W-1:0]  cfg_w_q, cfg_w_d;
    logic [CFG_W-1:0]  cfg_h_q, cfg_h_d;

    logic              fetch_req;
    logic              fetch_ack;
    logic              row_load;
    logic [ADDR_W-1:0] row_load_val;
    logic              more_col;
    logic              more_row;
    bank_t             bank;

    al_accel_ibuf_fetch u_fetch (
        .clk          (clk),
        .reset        (reset),
        .enb          (enb),
        .req          (fetch_req),
        .row_load     (row_load),
        .row_load_val (row_load_val),
        .col          (col_q),
        .cfg_w        (cfg_w_q),
        .mem_rreq     (mem_rreq),
        .mem_raddr    (mem_raddr),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .ack          (fetch_ack),
        .ibuf_di      (ibuf_di),
        .ibuf_ld_wrn  (ibuf_ld_wrn)
    );

    // Band geometry: another column in the scan direction, another row below.
    always_comb begin
        more_col = revert_q ? (col_q != '0)
                            : ({1'b0, col_q} + 9'd1 < {1'b0, cfg_w_q});
        more_row = ({1'b0, r_q} + 9'd3 < {1'b0, cfg_h_q});
    end

    // State-decoded outputs.
    always_comb begin
        fetch_req         = (state_q == ST_START) || (state_q == ST_STEP) || (state_q == ST_DOWN);
        bank              = BANK_1;
        case (state_q)
            ST_START, ST_STEP: bank = bank_t'(k_q + 2'd1);
            ST_DOWN:           bank = BANK_3;
            default:           bank = BANK_1;
        endcase
        ibuf_bank_sel     = bank;
        ibuf_conv_wstrb   = (ibuf_ld_wrn && (state_q == ST_STEP || state_q == ST_DOWN))
                            ? bank_strb(bank) : '0;
        ibuf_di_revert    = revert_q;
        win_valid         = (state_q == ST_SHIFT);
        ibuf_conv_fi_load = (state_q == ST_SWAP);
        ibuf_conv_se_load = (state_q == ST_SWAP);
        busy              = (state_q != ST_IDLE);
        done              = (state_q == ST_FIN);
    end

    // Next-state and counter updates; nothing advances while enb is low.
    always_comb begin
        state_d      = state_q;
        r_d          = r_q;
        col_d        = col_q;
        k_d          = k_q;
        sh_d         = sh_q;
        revert_d     = revert_q;
        band_d       = band_q;
        cfg_w_d      = cfg_w_q;
        cfg_h_d      = cfg_h_q;
        row_load     = 1'b0;
        row_load_val = band_q;
        if (enb) begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        cfg_w_d = cfg_w;
                        cfg_h_d = cfg_h;
                        if (cfg_h < 8'd3 || cfg_w == '0) begin
                            state_d = ST_FIN;
                        end else begin
                            state_d      = ST_START;
                            r_d          = '0;
                            col_d        = '0;
                            k_d          = '0;
                            sh_d         = '0;
                            revert_d     = 1'b0;
                            band_d       = cfg_base;
                            row_load     = 1'b1;
                            row_load_val = cfg_base;
                        end
                    end
                end
                ST_START, ST_STEP: begin
                    if (fetch_ack) begin
                        if (k_q == 2'd2) begin
                            k_d     = '0;
                            sh_d    = '0;
                            state_d = ST_SHIFT;
                        end else begin
                            k_d = k_q + 2'd1;
                        end
                    end
                end
                ST_SHIFT: begin
                    sh_d = sh_q + SH_W'(1);
                    if (sh_q == SH_W'(SHIFT_LEN - 1)) begin
                        sh_d = '0;
                        if (more_col) begin
                            state_d  = ST_STEP;
                            col_d    = revert_q ? col_q - 8'd1 : col_q + 8'd1;
                            k_d      = '0;
                            row_load = 1'b1;
                        end else if (more_row) begin
                            // Accumulator already sits at row r+3 after the last group.
                            state_d = ST_DOWN;
                        end else begin
                            state_d = ST_FIN;
                        end
                    end
                end
                ST_DOWN: begin
                    if (fetch_ack) begin
                        state_d = ST_SWAP;
                    end
                end
                ST_SWAP: begin
                    r_d      = r_q + 8'd1;
                    revert_d = ~revert_q;
                    band_d   = band_q + ADDR_W'(cfg_w_q);
                    sh_d     = '0;
                    state_d  = ST_SHIFT;
                end
                ST_FIN: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            r_q      <= '0;
            col_q    <= '0;
            k_q      <= '0;
            sh_q     <= '0;
            revert_q <= 1'b0;
            band_q   <= '0;
            cfg_w_q  <= '0;
            cfg_h_q  <= '0;
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            col_q    <= col_d;
            k_q      <= k_d;
            sh_q     <= sh_d;
            revert_q <= revert_d;
            band_q   <= band_d;
            cfg_w_q  <= cfg_w_d;
            cfg_h_q  <= cfg_h_d;
        end
    end

endmodule

// File: tb/tb_al_accel_ibuf_seq.sv
// Scoreboard bench for the input-buffer scan sequencer.
module tb_al_accel_ibuf_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        enb;
    logic        start;
    logic [15:0] cfg_base;
    logic [7:0]  cfg_w;
    logic [7:0]  cfg_h;
    logic        mem_rreq;
    logic [15:0] mem_raddr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] ibuf_di;
    logic        ibuf_ld_wrn;
    logic [1:0]  ibuf_bank_sel;
    logic        ibuf_di_revert;
    logic [2:0]  ibuf_conv_wstrb;
    logic        ibuf_conv_fi_load;
    logic        ibuf_conv_se_load;
    logic        win_valid;
    logic        busy;
    logic        done;

    al_accel_ibuf_seq dut (
        .clk               (clk),
        .reset             (reset),
        .enb               (enb),
        .start             (start),
        .cfg_base          (cfg_base),
        .cfg_w             (cfg_w),
        .cfg_h             (cfg_h),
        .mem_rreq          (mem_rreq),
        .mem_raddr         (mem_raddr),
        .mem_rvalid        (mem_rvalid),
        .mem_rdata         (mem_rdata),
        .ibuf_di           (ibuf_di),
        .ibuf_ld_wrn       (ibuf_ld_wrn),
        .ibuf_bank_sel     (ibuf_bank_sel),
        .ibuf_di_revert    (ibuf_di_revert),
        .ibuf_conv_wstrb   (ibuf_conv_wstrb),
        .ibuf_conv_fi_load (ibuf_conv_fi_load),
        .ibuf_conv_se_load (ibuf_conv_se_load),
        .win_valid         (win_valid),
        .busy              (busy),
        .done              (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [1:0]  bank;
        logic        rev;
        logic        first;
    } ld_t;

    ld_t         exp_q[$];
    int          total = 0;
    int          bad   = 0;
    int          win_cnt, swap_cnt, done_cnt;
    int          exp_win, exp_swap;
    int unsigned mem_lat = 0;
    int unsigned lat_cnt = 0;
    logic        enb_man = 1'b1;
    logic        jitter  = 1'b0;
    logic        rnd_q   = 1'b1;

    function automatic logic [31:0] mdata(input logic [15:0] a);
        return {a ^ 16'h5A3C, ~a};
    endfunction

    // Memory: data is a function of address; rvalid after mem_lat waiting cycles, held until taken.
    assign mem_rdata  = mdata(mem_raddr);
    assign mem_rvalid = mem_rreq && (lat_cnt >= mem_lat);
    always @(posedge clk) begin
        if (reset || !mem_rreq || (mem_rvalid && enb)) lat_cnt <= 0;
        else if (lat_cnt < mem_lat) lat_cnt <= lat_cnt + 1;
    end

    always @(posedge clk) rnd_q <= ($urandom_range(3) != 0);
    assign enb = enb_man & (start | !jitter | rnd_q);

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ld(input logic [15:0] base, input int w, input int row, input int c,
                           input int bank, input int rev, input bit first);
        ld_t e;
        e.addr  = 16'(int'(base) + row * w + c);
        e.bank  = 2'(bank);
        e.rev   = 1'(rev);
        e.first = first;
        exp_q.push_back(e);
    endtask

    // Reference: bands of 3 rows walked in serpentine order; every column of a band is
    // a 4-window shift, new columns need 3 words, each band change needs one word (row+3).
    task automatic build_model(input logic [15:0] base, input int w, input int h);
        int c;
        exp_q.delete();
        exp_win  = 0;
        exp_swap = 0;
        if (h < 3 || w == 0) return;
        for (int b = 0; b <= h - 3; b++) begin
            for (int i = 0; i < w; i++) begin
                c = (b % 2 == 0) ? i : w - 1 - i;
                if (b == 0 || i > 0)
                    for (int k = 0; k < 3; k++) push_ld(base, w, b + k, c, k + 1, b % 2, (b == 0 && i == 0));
                exp_win += 4;
            end
            if (b + 3 < h) begin
                push_ld(base, w, b + 3, (b % 2 == 0) ? w - 1 : 0, 3, b % 2, 1'b0);
                exp_swap++;
            end
        end
    endtask

    // Monitor: pops the scoreboard on every load, counts windows/swaps/done, checks handshake.
    initial begin
        ld_t         e;
        logic        prev_pend = 1'b0;
        logic [15:0] prev_addr = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_pend = 1'b0;
            end else begin
                if (enb && win_valid) win_cnt++;
                if (enb && ibuf_conv_fi_load && ibuf_conv_se_load) swap_cnt++;
                if (enb && done) done_cnt++;
                if (win_valid || ibuf_conv_fi_load || ibuf_conv_se_load)
                    check("pulse_vs_load", ibuf_ld_wrn, 0);
                if (ibuf_conv_fi_load || ibuf_conv_se_load)
                    check("fi_se_pair", {ibuf_conv_fi_load, ibuf_conv_se_load}, 2'b11);
                if (prev_pend) begin
                    check("rreq_hold", mem_rreq, 1);
                    check("raddr_hold", mem_raddr, prev_addr);
                end
                prev_pend = mem_rreq && !(mem_rvalid && enb);
                prev_addr = mem_raddr;
                if (enb && ibuf_ld_wrn) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_load", mem_raddr, 16'hxxxx);
                    end else begin
                        e = exp_q.pop_front();
                        check("ld_addr", mem_raddr, e.addr);
                        check("ld_data", ibuf_di, mdata(e.addr));
                        check("ld_bank", ibuf_bank_sel, e.bank);
                        check("ld_revert", ibuf_di_revert, e.rev);
                        if (e.first) check("ld_wstrb_start", ibuf_conv_wstrb, 0);
                    end
                end
            end
        end
    end

    task automatic check_idle_outs(input string nm);
        check({nm, "_outs"}, {mem_rreq, mem_raddr, ibuf_di, ibuf_ld_wrn, ibuf_di_revert,
                              ibuf_conv_wstrb, ibuf_conv_fi_load, ibuf_conv_se_load, win_valid}, 0);
        check({nm, "_bank"}, ibuf_bank_sel, 2'd1);
        check({nm, "_busy"}, busy, 0);
        check({nm, "_done"}, done, 0);
    endtask

    // mode 0: plain scan; 1: extra start pulse while busy; 2: 5-cycle enb freeze mid-SHIFT.
    task automatic run_scan(input logic [15:0] base, input int w, input int h,
                            input int unsigned lat, input int mode);
        int cyc;
        mem_lat = lat;
        build_model(base, w, h);
        win_cnt = 0; swap_cnt = 0; done_cnt = 0;
        cfg_base = base; cfg_w = 8'(w); cfg_h = 8'(h);
        start = 1'b1;
        tick();
        start = 1'b0;
        if (mode == 1) begin
            repeat (3) tick();
            cfg_base = 16'h0000; cfg_w = 8'd1; cfg_h = 8'd7;
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        if (mode == 2) begin
            cyc = 0;
            while (!win_valid && cyc < 500) begin tick(); cyc++; end
            check("freeze_reach_shift", win_valid, 1);
            enb_man = 1'b0;
            repeat (5) begin
                @(negedge clk);
                check("freeze_state", {win_valid, busy, mem_rreq, ibuf_ld_wrn, done}, 5'b11000);
                tick();
            end
            enb_man = 1'b1;
        end
        cyc = 0;
        while (done_cnt == 0 && cyc < 4000) begin tick(); cyc++; end
        repeat (2) tick();
        check("done_pulses", done_cnt, 1);
        check("win_count", win_cnt, exp_win);
        check("swap_count", swap_cnt, exp_swap);
        check("loads_left", exp_q.size(), 0);
        check("busy_after", busy, 0);
    endtask

    initial begin
        int cyc;
        reset = 1'b1; start = 1'b0;
        cfg_base = '0; cfg_w = '0; cfg_h = '0;
        repeat (2) tick();
        @(negedge clk);
        check_idle_outs("reset");
        tick();
        reset = 1'b0;
        tick();

        run_scan(16'h0100, 2, 3, 0, 0);
        run_scan(16'h0100, 2, 4, 0, 0);
        run_scan(16'h0100, 2, 4, 3, 0);
        run_scan(16'h0100, 2, 3, 0, 1);

        // Degenerate height: done the cycle after start, no reads.
        build_model(16'h0100, 3, 2);
        done_cnt = 0;
        cfg_base = 16'h0100; cfg_w = 8'd3; cfg_h = 8'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("short_done", {done, busy, mem_rreq}, 3'b110);
        tick();
        @(negedge clk);
        check("short_after", {done, busy, mem_rreq}, 3'b000);
        tick();

        // Reset in the middle of a SHIFT: scan abandoned, no done.
        build_model(16'h0100, 2, 3);
        done_cnt = 0;
        cfg_base = 16'h0100; cfg_w = 8'd2; cfg_h = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (!win_valid && cyc < 500) begin tick(); cyc++; end
        check("rst_reach_shift", win_valid, 1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle_outs("midreset");
        check("midreset_no_done", done_cnt, 0);
        reset = 1'b0;
        exp_q.delete();
        tick();
        run_scan(16'h0100, 2, 3, 0, 0);

        run_scan(16'h0200, 3, 4, 1, 2);

        for (int n = 0; n < 12; n++) begin
            jitter = (n % 2 == 1);
            run_scan(16'($urandom), int'($urandom_range(5)), int'($urandom_range(6)),
                     $urandom_range(3), 0);
        end
        jitter = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/al_accel_ibuf_seq.md
AL_ACCEL_IBUF_SEQ -- requirements
Module: al_accel_ibuf_seq

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high.
REQ-002 SHALL have ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- enb  in  1  clock enable; when low, all state holds.
- start  in  1  one-cycle pulse that begins a scan.
- cfg_base  in  16  word address of image row 0, column 0.
- cfg_w  in  8  image width in 32-bit words.
- cfg_h  in  8  image height in rows.
- mem_rreq  out  1  read request.
- mem_raddr  out  16  read word address.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read data.
- ibuf_di  out  32  word to the input buffer.
- ibuf_ld_wrn  out  1  1 = load, 0 = shift.
- ibuf_bank_sel  out  2  target bank, 1..3.
- ibuf_di_revert  out  1  scan direction, 1 = right-to-left.
- ibuf_conv_wstrb  out  3  write strobe.
- ibuf_conv_fi_load  out  1  first-load pulse.
- ibuf_conv_se_load  out  1  second-load pulse.
- win_valid  out  1  3x3 window is valid this cycle.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse at scan end.

Function
REQ-003 States SHALL be IDLE, START, SHIFT, STEP, DOWN, SWAP, FIN.
REQ-004 cfg_* SHALL be captured on an accepted start; start SHALL be ignored while busy=1.
REQ-005 In IDLE, start with cfg_h<3 or cfg_w=0 SHALL go to FIN directly, with no memory reads.
REQ-006 START SHALL fetch rows r, r+1, r+2 at column 0 into banks 1, 2, 3, with ld_wrn=1, wstrb=0, revert=0.
REQ-007 Fetch handshake:
- mem_rreq is held with a stable mem_raddr until mem_rvalid.
- At most one read is outstanding.
- ibuf_di=mem_rdata and ld_wrn=1 in the cycle mem_rvalid=1; ld_wrn=0 otherwise.
REQ-008 mem_raddr SHALL equal cfg_base + row*cfg_w + col, truncated to 16 bits.
- The row term comes from a running row-base accumulator, not a multiplier.
REQ-009 SHIFT SHALL run 4 cycles with ld_wrn=0 and win_valid=1 in each cycle.
REQ-010 After SHIFT, if a further column exists in the current direction, go to STEP; otherwise go to DOWN if r+3<cfg_h, else FIN.
REQ-011 STEP SHALL fetch rows r..r+2 at the next column (col±1) into banks 1..3, then return to SHIFT.
REQ-012 DOWN SHALL fetch row r+3 at the current column into bank 3, then go to SWAP.
REQ-013 SWAP SHALL last 1 cycle with ld_wrn=0, fi_load=1, se_load=1; it then increments r, toggles revert, and goes to SHIFT.
REQ-014 ibuf_di_revert SHALL be constant within a band and toggle only at SWAP.
REQ-015 In FIN, done=1 for one cycle, then the block returns to IDLE; busy=1 in every state except IDLE.
REQ-016 fi_load, se_load and win_valid SHALL be single-cycle, never asserted while ld_wrn=1.
REQ-017 With enb=0, the state, counters and all outputs SHALL freeze; an outstanding rvalid SHALL NOT be lost (the sequencer only samples when enb=1; memory holds rvalid).

Reset
REQ-018 On reset, all outputs SHALL be 0, ibuf_bank_sel=1, state=IDLE, and counters cleared; reset mid-scan SHALL abandon the scan without a done pulse.

Structure
REQ-019 A shared package (al_accel_pkg) SHALL hold the state enumeration, SHIFT_LEN=4, bank codes 1..3, and the address and config widths.
REQ-020 The fetch handshake (REQ-007/008) SHALL be a sub-module al_accel_ibuf_fetch; the FSM and counters stay top-level.

Verification
REQ-021 Scenarios:
- cfg_w=2, cfg_h=3, base=0x0100, zero-latency memory → addresses 0x100,0x102,0x104,0x101,0x103,0x105; 8 win_valid; no SWAP; done once.
- cfg_w=2, cfg_h=4 → one DOWN read at 0x107 (row 3, col 1), one SWAP cycle with fi_load=se_load=1, revert 0→1, next STEP column 0; 16 win_valid total.
- Memory latency 3 cycles on every read → mem_raddr stable while mem_rreq high; no extra ld_wrn pulses; same window count as the zero-latency run.
- Second start pulse while busy, and start with cfg_h=2 → first ignored; second gives done 1 cycle after start, no mem_rreq.
- reset asserted during a SHIFT cycle → next cycle all outputs 0, bank_sel=1, busy=0, no done; a fresh start then completes normally.
- enb low for 5 cycles mid-SHIFT → outputs frozen; win_valid count unchanged at the end.
